// File: rtl/uart_echo_ctrl.sv
// UART echo/test controller: buffers rx words in a FIFO and echoes them in order,
// and sends a burst of test words after the button has been held long enough.
module uart_echo_ctrl #(
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       FIFO_AW     = 4,
  parameter int unsigned       HOLD_CYCLES = 50_000_000,
  parameter logic [DATA_W-1:0] TEST_WORD   = DATA_W'(8'hFF),
  parameter int unsigned       BURST_LEN   = 1,
  parameter bit                BURST_INC   = 1'b0
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               btn_n,
  input  logic               rx_finish,
  input  logic [DATA_W-1:0]  rx_data,
  input  logic               tx_finish,
  output logic               tx_data_en,
  output logic [DATA_W-1:0]  tx_data_in,
  output logic               led_on,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);

  localparam int unsigned DEPTH  = 2 ** FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IDX_W  = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_W-1:0]     mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [IDX_W-1:0]      burst_idx;
  logic                  burst_pend, burst_fly;
  logic                  tx_en_nxt;
  logic [DATA_W-1:0]     tx_data_nxt;

  logic                  fifo_empty_c, fifo_full_c, pop_c, push_c;
  logic                  load_burst_c, burst_last_c, trigger_c;
  logic [DATA_W-1:0]     burst_word_c;

  assign fifo_empty_c = (fifo_count == '0);
  assign fifo_full_c  = (fifo_count == CNT_W'(DEPTH));
  assign load_burst_c = (state == IDLE) && burst_pend;
  assign pop_c        = (state == IDLE) && !burst_pend && !fifo_empty_c;
  assign push_c       = rx_finish && (!fifo_full_c || pop_c);
  assign burst_last_c = (burst_idx == IDX_W'(BURST_LEN - 1));
  // A burst already pending or with its last word still on the wire blocks a new one.
  assign trigger_c    = !btn_n && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) &&
                        !burst_pend && !burst_fly;
  assign burst_word_c = BURST_INC ? TEST_WORD + DATA_W'(burst_idx) : TEST_WORD;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (burst_pend || !fifo_empty_c) state_nxt = SEND;
      SEND:      state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_finish) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output logic: burst words take priority over queued echo words
  always_comb begin
    tx_en_nxt   = 1'b0;
    tx_data_nxt = tx_data_in;
    if (load_burst_c) begin
      tx_en_nxt   = 1'b1;
      tx_data_nxt = burst_word_c;
    end else if (pop_c) begin
      tx_en_nxt   = 1'b1;
      tx_data_nxt = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tx_data_en <= 1'b0;
      tx_data_in <= '0;
      led_on     <= 1'b0;
    end else begin
      tx_data_en <= tx_en_nxt;
      tx_data_in <= tx_data_nxt;
      led_on     <= ~btn_n;
    end
  end

  // FIFO storage
  always_ff @(posedge clk_in) begin
    if (push_c) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      if (push_c && !pop_c)      fifo_count <= fifo_count + CNT_W'(1);
      else if (pop_c && !push_c) fifo_count <= fifo_count - CNT_W'(1);
      if (rx_finish && !push_c) overflow <= 1'b1;
    end
  end

  // Button hold counter and burst sequencing
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hold_cnt   <= '0;
      burst_pend <= 1'b0;
      burst_fly  <= 1'b0;
      burst_idx  <= '0;
    end else begin
      if (btn_n)                                hold_cnt <= '0;
      else if (hold_cnt != HOLD_W'(HOLD_CYCLES)) hold_cnt <= hold_cnt + HOLD_W'(1);
      if (trigger_c) begin
        burst_pend <= 1'b1;
        burst_idx  <= '0;
      end else if (load_burst_c) begin
        burst_idx <= burst_idx + IDX_W'(1);
        if (burst_last_c) begin
          burst_pend <= 1'b0;
          burst_fly  <= 1'b1;
        end
      end
      if (burst_fly && (state == WAIT_DONE) && tx_finish) burst_fly <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl with a uart_tx responder that
// completes each frame 20 cycles after tx_data_en.
module tb_uart_echo_ctrl;

  logic       clk_in    = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_n     = 1'b1;
  logic       rx_finish = 1'b0;
  logic [7:0] rx_data   = 8'h00;
  logic       tx_finish = 1'b0;
  logic       tx_data_en;
  logic [7:0] tx_data_in;
  logic       led_on;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got [$];
  logic [7:0] cur      = 8'h00;
  int         resp_cnt = 0;
  bit         busy     = 1'b0;
  bit         stall    = 1'b0;
  int         unstable = 0;
  int         en_busy  = 0;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] exp_tx;
    logic [2:0] exp_cnt_wr;
    logic [2:0] exp_cnt_pop;
  } vec_t;
  vec_t vecs [4];

  uart_echo_ctrl #(
    .DATA_W(8), .FIFO_AW(2), .HOLD_CYCLES(10), .TEST_WORD(8'hFE),
    .BURST_LEN(3), .BURST_INC(1'b1)
  ) dut (
    .clk_in(clk_in), .rst(rst), .btn_n(btn_n), .rx_finish(rx_finish),
    .rx_data(rx_data), .tx_finish(tx_finish), .tx_data_en(tx_data_en),
    .tx_data_in(tx_data_in), .led_on(led_on), .fifo_count(fifo_count),
    .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  // uart_tx stand-in: logs each started word, finishes it 20 cycles later
  always @(negedge clk_in) begin
    if (rst) begin
      busy      = 1'b0;
      tx_finish = 1'b0;
    end else begin
      tx_finish = 1'b0;
      if (busy && !stall) begin
        if (resp_cnt == 1) begin
          tx_finish = 1'b1;
          busy      = 1'b0;
          if (tx_data_in !== cur) unstable++;
        end
        resp_cnt--;
      end
      if (tx_data_en === 1'b1) begin
        if (busy) en_busy++;
        got.push_back(tx_data_in);
        cur      = tx_data_in;
        busy     = 1'b1;
        resp_cnt = 20;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_finish = 1'b1;
    rx_data   = d;
    @(negedge clk_in);
    rx_finish = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while ((got.size() < target || busy) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    int base;
    logic [7:0] exp_burst [4];
    exp_burst[0] = 8'hFE; exp_burst[1] = 8'hFF; exp_burst[2] = 8'h00; exp_burst[3] = 8'h55;

    vecs[0] = '{8'h41, 8'h41, 3'd1, 3'd0};
    vecs[1] = '{8'h00, 8'h00, 3'd1, 3'd0};
    vecs[2] = '{8'hA5, 8'hA5, 3'd1, 3'd0};
    vecs[3] = '{8'hFF, 8'hFF, 3'd1, 3'd0};

    // Reset state
    repeat (3) @(negedge clk_in);
    chk("rst_tx_en",    32'(tx_data_en), 32'd0);
    chk("rst_tx_data",  32'(tx_data_in), 32'd0);
    chk("rst_led",      32'(led_on),     32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow),   32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // Single-word echo, latency t+2
    for (int i = 0; i < 4; i++) begin
      base = got.size();
      send_rx(vecs[i].rx);
      chk("echo_en_t1",  32'(tx_data_en), 32'd0);
      chk("echo_cnt_wr", 32'(fifo_count), 32'(vecs[i].exp_cnt_wr));
      @(negedge clk_in);
      chk("echo_en_t2",   32'(tx_data_en), 32'd1);
      chk("echo_data_t2", 32'(tx_data_in), 32'(vecs[i].exp_tx));
      chk("echo_cnt_pop", 32'(fifo_count), 32'(vecs[i].exp_cnt_pop));
      wait_frames(base + 1, 100, "echo_timeout");
      chk("echo_logged", 32'(got[base]), 32'(vecs[i].exp_tx));
    end

    // Five back-to-back words, no overflow
    base = got.size();
    for (int i = 0; i < 5; i++) send_rx(8'(8'h41 + i));
    wait_frames(base + 5, 300, "b2b_timeout");
    for (int i = 0; i < 5; i++) chk("b2b_order", 32'(got[base + i]), 32'(8'h41 + i));
    chk("b2b_overflow", 32'(overflow),   32'd0);
    chk("b2b_count",    32'(fifo_count), 32'd0);

    // Six words while the transmitter stalls: one in flight, four buffered, one dropped
    stall = 1'b1;
    base  = got.size();
    for (int i = 0; i < 6; i++) send_rx(8'(8'h61 + i));
    repeat (3) @(negedge clk_in);
    chk("full_count",    32'(fifo_count), 32'd4);
    chk("full_overflow", 32'(overflow),   32'd1);
    chk("full_inflight", 32'(got.size()), 32'(base + 1));
    stall = 1'b0;
    wait_frames(base + 5, 300, "full_timeout");
    for (int i = 0; i < 5; i++) chk("full_order", 32'(got[base + i]), 32'(8'h61 + i));
    chk("full_drained", 32'(got.size()), 32'(base + 5));

    // Nine-cycle press: LED follows, no burst
    base  = got.size();
    btn_n = 1'b0;
    @(negedge clk_in);
    chk("led_on", 32'(led_on), 32'd1);
    repeat (8) @(negedge clk_in);
    btn_n = 1'b1;
    @(negedge clk_in);
    chk("led_off", 32'(led_on), 32'd0);
    repeat (40) @(negedge clk_in);
    chk("short_press", 32'(got.size()), 32'(base));

    // Thirty-cycle press: one burst FE,FF,00
    btn_n = 1'b0;
    repeat (30) @(negedge clk_in);
    btn_n = 1'b1;
    wait_frames(base + 3, 400, "burst_timeout");
    for (int i = 0; i < 3; i++) chk("burst_word", 32'(got[base + i]), 32'(exp_burst[i]));
    repeat (60) @(negedge clk_in);
    chk("burst_once",       32'(got.size()), 32'(base + 3));
    chk("overflow_sticky",  32'(overflow),   32'd1);

    // Echo word arriving with the trigger is sent after the burst
    base  = got.size();
    btn_n = 1'b0;
    repeat (9) @(negedge clk_in);
    send_rx(8'h55);
    repeat (2) @(negedge clk_in);
    btn_n = 1'b1;
    wait_frames(base + 4, 400, "prio_timeout");
    for (int i = 0; i < 4; i++) chk("prio_order", 32'(got[base + i]), 32'(exp_burst[i]));

    // Reset while waiting on a frame with two words buffered
    stall = 1'b1;
    base  = got.size();
    send_rx(8'h71);
    send_rx(8'h72);
    send_rx(8'h73);
    repeat (5) @(negedge clk_in);
    chk("pre_rst_count",    32'(fifo_count), 32'd2);
    chk("pre_rst_inflight", 32'(got.size()), 32'(base + 1));
    rst = 1'b1;
    @(negedge clk_in);
    chk("mid_rst_tx_en",    32'(tx_data_en), 32'd0);
    chk("mid_rst_tx_data",  32'(tx_data_in), 32'd0);
    chk("mid_rst_count",    32'(fifo_count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow),   32'd0);
    rst   = 1'b0;
    stall = 1'b0;
    base  = got.size();
    repeat (60) @(negedge clk_in);
    chk("post_rst_silent", 32'(got.size()), 32'(base));
    chk("post_rst_count",  32'(fifo_count), 32'd0);

    chk("tx_data_stable", 32'(unstable), 32'd0);
    chk("en_while_busy",  32'(en_busy),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
